ov7670_emulator: RTL

- Transmit-side model of the OV7670 parallel camera bus. Drives pclk, cvSync, href and cData with RGB444 frame timing from the system clock.
- Sits in the camera peripheral as an on-chip stand-in for the sensor, for bring-up and loopback into the pixel receiver.
- Pixel values come from an external request/data interface or, optionally, from an internal colour-bar generator.

---
 rtl/ov7670_pkg.sv | 35 +++
 rtl/ov7670_if.sv | 18 +
 rtl/ov7670_pclk_gen.sv | 34 +++
 rtl/ov7670_emulator.sv | 104 ++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared types, default timing and byte formats for the OV7670 bus emulator
package ov7670_pkg;
    typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_H_BLANK = 288;
    localparam int DEF_VSYNC_LINES = 3;
    localparam int DEF_VBP_LINES = 17;
    localparam int DEF_VFP_LINES = 10;
    localparam int DEF_PCLK_DIV = 2;
    localparam logic [3:0] HI_PAD = 4'h0;
    function automatic logic [7:0] byte_hi(rgb444_t p);
        return {HI_PAD, p.r};
    endfunction
    function automatic logic [7:0] byte_lo(rgb444_t p);
        return {p.g, p.b};
    endfunction
    function automatic rgb444_t bar_rgb(logic [2:0] k);
        return '{r: {4{k[2]}}, g: {4{k[1]}}, b: {4{k[0]}}};
    endfunction
    function automatic int max4(int a, int b, int c, int d);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return m > d ? m : d;
    endfunction
    function automatic int clog2_min1(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ov7670_if.sv
// ov7670_if: camera bus, pixel request and frame status signals of the emulator
interface ov7670_if;
    logic pclk;
    logic cvSync;
    logic href;
    logic [7:0] cData;
    logic pix_req;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic [11:0] pix_rgb;
    logic frame_start;
    logic frame_done;
    logic busy;
    modport master (output pclk, cvSync, href, cData, pix_req, pix_x, pix_y, frame_start, frame_done, busy,
                    input pix_rgb);
    modport slave (input pclk, cvSync, href, cData, pix_req, pix_x, pix_y, frame_start, frame_done, busy,
                   output pix_rgb);
endinterface

// File: rtl/ov7670_pclk_gen.sv
// ov7670_pclk_gen: divides clk into pclk and flags the clk cycles around its edges
module ov7670_pclk_gen
    import ov7670_pkg::*;
#(
    parameter int PCLK_DIV = DEF_PCLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic pclk,
    output logic rise_tick,
    output logic fall_tick,
    output logic fall_next
);
    localparam int W = clog2_min1(PCLK_DIV);
    logic [W-1:0] cnt, cnt_inc;
    logic tick;
    always_comb begin
        tick = cnt == W'(PCLK_DIV - 1);
        cnt_inc = cnt + 1'b1;
        rise_tick = tick & ~pclk;
        fall_tick = tick & pclk;
        // only meaningful for PCLK_DIV > 1; with PCLK_DIV == 1 the cycle before a fall is rise_tick
        fall_next = ~tick & pclk & (cnt_inc == W'(PCLK_DIV - 1));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            pclk <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt_inc;
            pclk <= pclk ^ tick;
        end
    end
endmodule

// File: rtl/ov7670_emulator.sv
// ov7670_emulator: OV7670 RGB444 transmit-side bus model with frame timing from clk
// OV7670_TEST_PATTERN_EN replaces pix_rgb with eight internal vertical colour bars.
module ov7670_emulator
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int H_BLANK = DEF_H_BLANK,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int VBP_LINES = DEF_VBP_LINES,
    parameter int VFP_LINES = DEF_VFP_LINES,
    parameter int PCLK_DIV = DEF_PCLK_DIV
) (
    input logic clk,
    input logic rst,
    input logic en,
    ov7670_if.master bus
);
    localparam int LINE_PCLKS = 2 * H_ACTIVE + H_BLANK;
    localparam int BW = clog2_min1(LINE_PCLKS);
    localparam int LW = clog2_min1(max4(VSYNC_LINES, VBP_LINES, V_ACTIVE, VFP_LINES));
`ifdef OV7670_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE >= 8 ? H_ACTIVE / 8 : 1;
`endif
    state_t state, nstate;
    logic [BW-1:0] byte_cnt, nbyte;
    logic [LW-1:0] line_cnt, nline;
    logic pclk, rise_tick, fall_tick, fall_next, pre_fall, nhref;
    rgb444_t rgb_q, rgb_d;
    int lines;

    ov7670_pclk_gen #(.PCLK_DIV(PCLK_DIV)) u_pclk (
        .clk(clk),
        .rst(rst),
        .pclk(pclk),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick),
        .fall_next(fall_next)
    );

    assign bus.pclk = pclk;
    assign pre_fall = PCLK_DIV == 1 ? rise_tick : fall_next;

    // Registers hold the position on the bus now; n* is the position entered at the next fall_tick.
    always_comb begin
        lines = state == VSYNC ? VSYNC_LINES : state == VBP ? VBP_LINES : state == ACTIVE ? V_ACTIVE : VFP_LINES;
        nbyte = byte_cnt == BW'(LINE_PCLKS - 1) ? '0 : byte_cnt + 1'b1;
        nline = line_cnt;
        nstate = state;
        if (state == IDLE) begin
            nbyte = '0;
            nstate = en ? VSYNC : IDLE;
        end else if (byte_cnt == BW'(LINE_PCLKS - 1)) begin
            nline = line_cnt + 1'b1;
            if (int'(line_cnt) == lines - 1) begin
                nline = '0;
                nstate = state == VSYNC ? (VBP_LINES > 0 ? VBP : ACTIVE) :
                         state == VBP ? ACTIVE :
                         state == ACTIVE && VFP_LINES > 0 ? VFP :
                         en ? VSYNC : IDLE;
            end
        end
        nhref = nstate == ACTIVE && int'(nbyte) < 2 * H_ACTIVE;
        bus.pix_req = pre_fall && nhref && !nbyte[0];
        bus.pix_x = bus.pix_req ? 10'(nbyte >> 1) : '0;
        bus.pix_y = bus.pix_req ? 9'(nline) : '0;
`ifdef OV7670_TEST_PATTERN_EN
        rgb_d = bar_rgb(3'(int'(bus.pix_x) / BAR_W));
`else
        rgb_d = bus.pix_rgb;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            byte_cnt <= '0;
            line_cnt <= '0;
            rgb_q <= '0;
            bus.cvSync <= 1'b0;
            bus.href <= 1'b0;
            bus.cData <= '0;
            bus.frame_start <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            bus.frame_start <= 1'b0;
            bus.frame_done <= 1'b0;
            if (bus.pix_req)
                rgb_q <= rgb_d;
            if (fall_tick) begin
                state <= nstate;
                byte_cnt <= nbyte;
                line_cnt <= nline;
                bus.cvSync <= nstate == VSYNC;
                bus.href <= nhref;
                bus.cData <= !nhref ? '0 : nbyte[0] ? byte_lo(rgb_q) : byte_hi(rgb_q);
                bus.frame_start <= nstate == VSYNC && state != VSYNC;
                bus.frame_done <= state == ACTIVE && nstate != ACTIVE;
                bus.busy <= nstate != IDLE;
            end
        end
    end
endmodule
